reg_file_scoreboard: RTL and testbench
======================================

// Module: reg_file_scoreboard
// PURPOSE
//  ARM integer register file (R0-R14) plus a per-register pending-write scoreboard.
//  Sits in decode, directly upstream of the operand-select muxes.
//  Supplies the Rn, Rm and Rd (store-data) operands, and busy flags the hazard logic uses to drive the mux selects.
//  Reads are combinational with write-through bypass. Writes and the scoreboard update on the clock edge.
// PARAMETERS
//  WIDTH     32  data width of each register and of pc_plus8
//  MAX_PEND  3   max in-flight writes tracked per register (EX/MEM/WB)
//  CNT_W     2   scoreboard counter width; must satisfy 2**CNT_W > MAX_PEND
// PORTS
//  clk         in   1      single clock, rising edge
//  rst         in   1      synchronous, active-high reset
//  rn_addr     in   4      read port A address
//  rm_addr     in   4      read port B address
//  rd_addr     in   4      read port C address (store data)
//  pc_plus8    in   WIDTH  value returned for reads of R15
//  rn_data     out  WIDTH  port A data
//  rm_data     out  WIDTH  port B data
//  rd_data     out  WIDTH  port C data
//  rn_busy     out  1      port A register has pending writes
//  rm_busy     out  1      port B register has pending writes
//  rd_busy     out  1      port C register has pending writes
//  wb_en       in   1      writeback strobe
//  wb_addr     in   4      writeback destination
//  wb_data     in   WIDTH  writeback value
//  issue_en    in   1      an instruction with a register destination enters EX
//  issue_addr  in   4      destination of the issuing instruction
//  sb_err      out  1      sticky error: scoreboard overflow or underflow
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - R0-R14 <= 0; all counters <= 0; sb_err <= 0.
//   - rst overrides wb_en and issue_en in the same cycle.
//   - Reset mid-operation discards all pending state.
//  Read, per port, combinational, 0-cycle latency:
//   - addr==15: data=pc_plus8, busy=0.
//   - wb_en && wb_addr==addr && addr!=15: data=wb_data (bypass).
//   - otherwise data=R[addr].
//   - busy = (cnt[addr]!=0). Busy is not bypassed.
//  Write, at posedge:
//   - If wb_en and wb_addr!=15: R[wb_addr] <= wb_data.
//   - Writes to R15 are ignored; the PC is owned by fetch.
//  Scoreboard, per register i in 0..14, at posedge:
//   - inc = issue_en && issue_addr==i; dec = wb_en && wb_addr==i.
//   - inc && dec: cnt unchanged.
//   - inc only: cnt+1 if cnt<MAX_PEND; else hold and set sb_err (overflow).
//   - dec only: cnt-1 if cnt>0; else hold at 0 and set sb_err (underflow). The register write still happens.
//   - Address 15 is never tracked: issue/wb to 15 leaves all counters unchanged and raises no error.
//  sb_err: sticky; cleared only by rst.
//  No internal state machine beyond the counters. Outputs are glitch-tolerant combinational functions of state and inputs.
// STRUCTURE
//  Shared package arm_pkg:
//   - REG_PC = 4'hF; NUM_GPR = 15; DATA_W = 32.
//  Sub-module sb_counter (CNT_W, MAX_PEND):
//   - inputs clk, rst, inc, dec; outputs cnt, busy, ovf, unf.
//   - Instantiated 15 times in a generate loop.
//  Top level holds:
//   - the register array and write logic;
//   - three identical read/bypass paths, as a function or generate;
//   - the sb_err OR-reduction register.
// TESTING
//  1. Reset, then read R0-R14 -> all data 0, busy 0, sb_err 0. Read R15 with pc_plus8=0x108 -> 0x108.
//  2. wb_en=1, wb_addr=3, wb_data=0xDEADBEEF with rn_addr=3 in the same cycle -> rn_data=0xDEADBEEF immediately; R3 holds it after the edge.
//  3. Issue R5 twice in consecutive cycles -> rm_busy(5)=1. First wb to R5 -> still busy. Second wb -> busy=0, sb_err=0.
//  4. Issue R7 and wb R7 in the same cycle while cnt=1 -> cnt stays 1, busy stays 1.
//  5. Four consecutive issues to R2 with no wb -> cnt saturates at 3, sb_err=1. wb to R9 with cnt=0 -> R9 written, sb_err stays 1.
//  6. wb_en to R15 with 0x55 -> no GPR changes, R15 read still returns pc_plus8. Assert rst while R4 is busy -> next cycle busy=0, R4=0, sb_err=0.

Source files
------------

// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared ARM register-file constants
package arm_pkg;
    localparam logic [3:0] REG_PC  = 4'hF;
    localparam int         NUM_GPR = 15;
    localparam int         DATA_W  = 32;
endpackage

// File: rtl/sb_counter.sv
// rtl/sb_counter.sv - saturating pending-write counter for one register
module sb_counter #(
    parameter int CNT_W    = 2,
    parameter int MAX_PEND = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             busy,
    output logic             ovf,
    output logic             unf
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PEND);

    // A simultaneous issue and writeback cancel out, even when saturated or empty.
    assign ovf  = inc && !dec && (cnt >= MAX_CNT);
    assign unf  = dec && !inc && (cnt == '0);
    assign busy = (cnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && !dec && !ovf) begin
            cnt <= cnt + CNT_W'(1);
        end else if (dec && !inc && !unf) begin
            cnt <= cnt - CNT_W'(1);
        end
    end
endmodule

// File: rtl/reg_file_scoreboard.sv
// rtl/reg_file_scoreboard.sv - R0-R14 register file with bypassed reads and pending-write scoreboard
module reg_file_scoreboard
    import arm_pkg::*;
#(
    parameter int WIDTH    = DATA_W,
    parameter int MAX_PEND = 3,
    parameter int CNT_W    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       rn_addr,
    input  logic [3:0]       rm_addr,
    input  logic [3:0]       rd_addr,
    input  logic [WIDTH-1:0] pc_plus8,
    output logic [WIDTH-1:0] rn_data,
    output logic [WIDTH-1:0] rm_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             rn_busy,
    output logic             rm_busy,
    output logic             rd_busy,
    input  logic             wb_en,
    input  logic [3:0]       wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    input  logic             issue_en,
    input  logic [3:0]       issue_addr,
    output logic             sb_err
);
    logic [WIDTH-1:0]             regs [NUM_GPR];
    logic [15:0]                  busy_vec;
    logic [NUM_GPR-1:0]           ovf_vec;
    logic [NUM_GPR-1:0]           unf_vec;
    logic [NUM_GPR-1:0][CNT_W-1:0] cnt_vec;
    logic                         cnt_unused;
    logic [2:0][3:0]              raddr;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_GPR; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && wb_addr != REG_PC) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // R15 belongs to fetch, so it has no counter and never reads busy.
    assign busy_vec[15] = 1'b0;

    for (genvar i = 0; i < NUM_GPR; i++) begin : g_sb
        sb_counter #(
            .CNT_W    (CNT_W),
            .MAX_PEND (MAX_PEND)
        ) u_cnt (
            .clk  (clk),
            .rst  (rst),
            .inc  (issue_en && issue_addr == 4'(i)),
            .dec  (wb_en && wb_addr == 4'(i)),
            .cnt  (cnt_vec[i]),
            .busy (busy_vec[i]),
            .ovf  (ovf_vec[i]),
            .unf  (unf_vec[i])
        );
    end

    assign cnt_unused = ^cnt_vec;

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_err <= 1'b0;
        end else if (|ovf_vec || |unf_vec) begin
            sb_err <= 1'b1;
        end
    end

    assign raddr = {rd_addr, rm_addr, rn_addr};

    // Data is bypassed from writeback; busy deliberately is not.
    for (genvar p = 0; p < 3; p++) begin : g_read
        logic [WIDTH-1:0] data;
        logic             busy;

        always_comb begin
            data = '0;
            if (raddr[p] == REG_PC) begin
                data = pc_plus8;
            end else if (wb_en && wb_addr == raddr[p]) begin
                data = wb_data;
            end else begin
                data = regs[raddr[p]];
            end
        end

        assign busy = busy_vec[raddr[p]];
    end

    assign rn_data = g_read[0].data;
    assign rm_data = g_read[1].data;
    assign rd_data = g_read[2].data;
    assign rn_busy = g_read[0].busy;
    assign rm_busy = g_read[1].busy;
    assign rd_busy = g_read[2].busy;
endmodule

// File: tb/tb_reg_file_scoreboard.sv
// tb/tb_reg_file_scoreboard.sv - scoreboard bench for reg_file_scoreboard
module tb_reg_file_scoreboard;
    localparam int SEL_RN_DATA = 0;
    localparam int SEL_RM_DATA = 1;
    localparam int SEL_RD_DATA = 2;
    localparam int SEL_RN_BUSY = 3;
    localparam int SEL_RM_BUSY = 4;
    localparam int SEL_RD_BUSY = 5;
    localparam int SEL_SB_ERR  = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  rn_addr, rm_addr, rd_addr;
    logic [31:0] pc_plus8;
    logic [31:0] rn_data, rm_data, rd_data;
    logic        rn_busy, rm_busy, rd_busy;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        issue_en;
    logic [3:0]  issue_addr;
    logic        sb_err;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    event sample_ev;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    reg_file_scoreboard dut (
        .clk        (clk),
        .rst        (rst),
        .rn_addr    (rn_addr),
        .rm_addr    (rm_addr),
        .rd_addr    (rd_addr),
        .pc_plus8   (pc_plus8),
        .rn_data    (rn_data),
        .rm_data    (rm_data),
        .rd_data    (rd_data),
        .rn_busy    (rn_busy),
        .rm_busy    (rm_busy),
        .rd_busy    (rd_busy),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .sb_err     (sb_err)
    );

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_RN_DATA: return rn_data;
            SEL_RM_DATA: return rm_data;
            SEL_RD_DATA: return rd_data;
            SEL_RN_BUSY: return {31'd0, rn_busy};
            SEL_RM_BUSY: return {31'd0, rm_busy};
            SEL_RD_BUSY: return {31'd0, rd_busy};
            default:     return {31'd0, sb_err};
        endcase
    endfunction

    initial begin : monitor
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(sample_ev);
            while (q.size() > 0) begin
                e   = q.pop_front();
                act = observe(e.sel);
                checks++;
                if (act !== e.exp) begin
                    failures++;
                    $display("FAIL %s actual=0x%08h required=0x%08h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic expect_val(input string n, input int sel, input logic [31:0] e);
        exp_t x;
        x.name = n;
        x.sel  = sel;
        x.exp  = e;
        q.push_back(x);
    endtask

    task automatic sample();
        #1;
        ->sample_ev;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        wb_en    = 1'b0;
        issue_en = 1'b0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        rst = 1'b1; rn_addr = 0; rm_addr = 0; rd_addr = 0; pc_plus8 = 32'h108;
        wb_en = 0; wb_addr = 0; wb_data = 0; issue_en = 0; issue_addr = 0;
        @(negedge clk);
        step();
        rst = 1'b0;

        // 1: reset state on every GPR, R15 returns pc_plus8
        expect_val("reset_sb_err", SEL_SB_ERR, 0);
        for (int i = 0; i < 15; i++) begin
            rn_addr = 4'(i); rm_addr = 4'(i); rd_addr = 4'(i);
            expect_val($sformatf("reset_rn_data_r%0d", i), SEL_RN_DATA, 0);
            expect_val($sformatf("reset_rd_busy_r%0d", i), SEL_RD_BUSY, 0);
            sample();
        end
        rn_addr = 4'hF;
        expect_val("r15_pc_plus8", SEL_RN_DATA, 32'h108);
        expect_val("r15_busy", SEL_RN_BUSY, 0);
        sample();

        // 2: issue R3, then bypass its writeback
        issue_en = 1; issue_addr = 3;
        step();
        idle();
        rn_addr = 3;
        expect_val("r3_busy_after_issue", SEL_RN_BUSY, 1);
        sample();
        wb_en = 1; wb_addr = 3; wb_data = 32'hDEADBEEF;
        expect_val("r3_bypass", SEL_RN_DATA, 32'hDEADBEEF);
        expect_val("r3_busy_not_bypassed", SEL_RN_BUSY, 1);
        sample();
        step();
        idle();
        expect_val("r3_stored", SEL_RN_DATA, 32'hDEADBEEF);
        expect_val("r3_busy_cleared", SEL_RN_BUSY, 0);
        expect_val("r3_sb_err", SEL_SB_ERR, 0);
        sample();

        // 3: two issues to R5, two writebacks
        issue_en = 1; issue_addr = 5;
        step();
        step();
        idle();
        rm_addr = 5;
        expect_val("r5_busy_two_pend", SEL_RM_BUSY, 1);
        sample();
        wb_en = 1; wb_addr = 5; wb_data = 32'h55555555;
        step();
        idle();
        expect_val("r5_busy_one_pend", SEL_RM_BUSY, 1);
        expect_val("r5_first_wb", SEL_RM_DATA, 32'h55555555);
        sample();
        wb_en = 1; wb_addr = 5; wb_data = 32'h12345678;
        step();
        idle();
        expect_val("r5_busy_done", SEL_RM_BUSY, 0);
        expect_val("r5_second_wb", SEL_RM_DATA, 32'h12345678);
        expect_val("r5_sb_err", SEL_SB_ERR, 0);
        sample();

        // 4: issue and wb R7 together while cnt=1 leaves cnt at 1
        issue_en = 1; issue_addr = 7;
        step();
        wb_en = 1; wb_addr = 7; wb_data = 32'h77;
        step();
        idle();
        rd_addr = 7;
        expect_val("r7_busy_held", SEL_RD_BUSY, 1);
        expect_val("r7_data", SEL_RD_DATA, 32'h77);
        sample();
        wb_en = 1; wb_addr = 7; wb_data = 32'h70;
        step();
        idle();
        expect_val("r7_busy_drained", SEL_RD_BUSY, 0);
        expect_val("r7_no_underflow", SEL_SB_ERR, 0);
        sample();

        // 5: overflow on R2, then underflow on R9
        rn_addr = 2;
        issue_en = 1; issue_addr = 2;
        step(); step(); step();
        expect_val("r2_three_pend_no_err", SEL_SB_ERR, 0);
        sample();
        step();
        idle();
        expect_val("r2_overflow_err", SEL_SB_ERR, 1);
        expect_val("r2_busy_sat", SEL_RN_BUSY, 1);
        sample();
        wb_en = 1; wb_addr = 2; wb_data = 32'h22;
        step(); step();
        expect_val("r2_busy_after_two_wb", SEL_RN_BUSY, 1);
        sample();
        step();
        idle();
        expect_val("r2_saturated_at_3", SEL_RN_BUSY, 0);
        sample();
        wb_en = 1; wb_addr = 9; wb_data = 32'h99;
        step();
        idle();
        rn_addr = 9;
        expect_val("r9_written_on_unf", SEL_RN_DATA, 32'h99);
        expect_val("r9_busy", SEL_RN_BUSY, 0);
        expect_val("sb_err_sticky", SEL_SB_ERR, 1);
        sample();

        // 6: reset while R4 busy, then writes/issues to R15 ignored
        issue_en = 1; issue_addr = 4;
        step();
        idle();
        rn_addr = 4;
        expect_val("r4_busy_pre_rst", SEL_RN_BUSY, 1);
        sample();
        rst = 1; issue_en = 1; issue_addr = 4; wb_en = 1; wb_addr = 4; wb_data = 32'h44;
        step();
        rst = 0;
        idle();
        rm_addr = 3;
        expect_val("r4_busy_post_rst", SEL_RN_BUSY, 0);
        expect_val("r4_data_post_rst", SEL_RN_DATA, 0);
        expect_val("r3_cleared_by_rst", SEL_RM_DATA, 0);
        expect_val("sb_err_cleared", SEL_SB_ERR, 0);
        sample();
        wb_en = 1; wb_addr = 4'hF; wb_data = 32'h55;
        issue_en = 1; issue_addr = 4'hF;
        rn_addr = 4'hF; rm_addr = 0; rd_addr = 4'hF;
        expect_val("r15_no_bypass", SEL_RN_DATA, 32'h108);
        sample();
        step();
        idle();
        pc_plus8 = 32'h200;
        expect_val("r15_still_pc", SEL_RN_DATA, 32'h200);
        expect_val("r15_never_busy", SEL_RD_BUSY, 0);
        expect_val("r0_untouched", SEL_RM_DATA, 0);
        expect_val("r15_no_err", SEL_SB_ERR, 0);
        sample();
        rm_addr = 14;
        expect_val("r14_untouched", SEL_RM_DATA, 0);
        sample();

        #2;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL queue_drained actual=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
